// File: rtl/dino_jump_ctrl_pkg.sv
// Shared game package: top-level game state, dino jump phase and a small
// helper for sizing counters.
//   state_t      : game FSM state driven by the game controller
//   jump_phase_t : vertical-motion phase of the dino sprite
//   cnt_width()  : bits needed to hold the values 0..max_val (at least 1)
package dino_jump_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WIN  = 2'd2,
    OVER = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } jump_phase_t;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dino_jump_ctrl_press_debouncer.sv
// press_debouncer: turns a synchronised, bouncy jump button into a single
// one-cycle accept pulse per physical press.
//   i_clk     : system clock
//   i_nrst    : asynchronous active-low reset
//   i_en      : counting enabled (game in RUN); counter held at 0 otherwise
//   i_button  : synchronised button level
//   o_accept  : combinational pulse on the cycle the counter reaches DEBOUNCE
// The counter saturates at DEBOUNCE so a held button never re-fires; the
// armed flag additionally demands a release between two accepted presses,
// which covers leaving and re-entering RUN with the button still held.
module press_debouncer
  import dino_jump_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 300000
) (
  input  logic i_clk,
  input  logic i_nrst,
  input  logic i_en,
  input  logic i_button,
  output logic o_accept
);

  localparam int unsigned     CW     = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0]   C_MAX  = CW'(DEBOUNCE);
  localparam logic [CW-1:0]   C_LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] r_cnt;
  logic          r_armed;
  logic          w_accept;

  // The press is accepted while the counter steps from DEBOUNCE-1 to
  // DEBOUNCE, so the consumer reacts on that same edge.
  assign w_accept = i_en && i_button && r_armed && (r_cnt == C_LAST);
  assign o_accept = w_accept;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_cnt   <= '0;
      r_armed <= 1'b0;
    end else begin
      if (!i_en || !i_button) begin
        r_cnt <= '0;
      end else if (r_cnt != C_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (!i_button) begin
        r_armed <= 1'b1;
      end else if (w_accept) begin
        r_armed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dino_jump_ctrl.sv
// dino_jump_ctrl: vertical-motion controller for the dino sprite.
//   clk, nRst     : system clock, asynchronous active-low reset
//   button        : synchronised jump button
//   state         : game state (IDLE/RUN/WIN/OVER)
//   drawDoneDino  : renderer finished redrawing the dino
//   dinoY         : current Y position (floor = FLOOR_Y, upward positive)
//   v             : signed vertical velocity, upward positive
//   dinoJumpGood  : one-cycle pulse on takeoff
//   airborne      : high while not resting on the floor
//   landed        : one-cycle pulse on touchdown
//   dinoMovement  : sticky "redraw needed" flag, cleared by drawDoneDino
// Physics advance once per TICK_DIV cycles while in RUN. Holding the button
// during ascent suppresses gravity for up to MAX_HOLD ticks (variable jump
// height). Position is clamped to [FLOOR_Y, CEIL_Y].
module dino_jump_ctrl
  import dino_jump_ctrl_pkg::*;
#(
  parameter int unsigned Y_W      = 8,
  parameter int unsigned V_W      = 8,
  parameter int unsigned FLOOR_Y  = 101,
  parameter int unsigned CEIL_Y   = 200,
  parameter int unsigned JUMP_V   = 10,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned TICK_DIV = 400000,
  parameter int unsigned DEBOUNCE = 300000
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  button,
  input  state_t                state,
  input  logic                  drawDoneDino,
  output logic [Y_W-1:0]        dinoY,
  output logic signed [V_W-1:0] v,
  output logic                  dinoJumpGood,
  output logic                  airborne,
  output logic                  landed,
  output logic                  dinoMovement
);

  // Position sums use Y_W+2 signed bits so that a downward step below zero
  // and an upward step past 2^Y_W are both visible to the clamps.
  localparam int unsigned SW = Y_W + 2;
  localparam int unsigned TW = cnt_width(TICK_DIV - 1);
  localparam int unsigned HW = cnt_width(MAX_HOLD);

  localparam logic [TW-1:0]         T_LAST    = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0]         H_MAX     = HW'(MAX_HOLD);
  localparam logic [Y_W-1:0]        Y_FLOOR   = Y_W'(FLOOR_Y);
  localparam logic [Y_W-1:0]        Y_CEIL    = Y_W'(CEIL_Y);
  localparam logic [Y_W-1:0]        Y_TAKEOFF = Y_W'(FLOOR_Y + JUMP_V);
  localparam logic signed [SW-1:0]  S_FLOOR   = SW'(FLOOR_Y);
  localparam logic signed [SW-1:0]  S_CEIL    = SW'(CEIL_Y);
  localparam logic signed [V_W-1:0] V_JUMP    = V_W'(JUMP_V);
  localparam logic signed [V_W-1:0] V_MIN     = {1'b1, {(V_W-1){1'b0}}};
  localparam logic signed [V_W:0]   G_EXT     = (V_W+1)'(GRAVITY);

  // Registered state
  jump_phase_t           r_phase;
  logic [Y_W-1:0]        r_y;
  logic signed [V_W-1:0] r_v;
  logic [HW-1:0]         r_hold;
  logic [TW-1:0]         r_tcnt;
  logic                  r_jump;
  logic                  r_land;
  logic                  r_air;
  logic                  r_mov;

  // Next-state and datapath
  jump_phase_t           w_phase_n;
  logic [Y_W-1:0]        w_y_n;
  logic signed [V_W-1:0] w_v_n;
  logic [HW-1:0]         w_hold_n;
  logic [TW-1:0]         w_tcnt_n;
  logic                  w_jump_n;
  logic                  w_land_n;
  logic                  w_air_n;
  logic                  w_mov_n;

  logic                  w_accept;
  logic                  w_tick;
  logic                  w_hold_tick;
  logic signed [SW-1:0]  w_sum;
  logic signed [V_W:0]   w_v_dec;
  logic signed [V_W-1:0] w_v_grav;
  logic signed [V_W-1:0] w_v_new;

  press_debouncer #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .i_clk    (clk),
    .i_nrst   (nRst),
    .i_en     (state == RUN),
    .i_button (button),
    .o_accept (w_accept)
  );

  assign w_tick      = (r_tcnt == T_LAST);
  assign w_hold_tick = (r_phase == RISE) && button && (r_hold < H_MAX);

  // y zero-extended, v sign-extended; requires V_W < Y_W+2.
  assign w_sum = $signed({2'b00, r_y}) + $signed({{(SW-V_W){r_v[V_W-1]}}, r_v});

  // Gravity step with saturation at the most negative velocity: an overflow
  // of the one-bit-wider difference can only be in the downward direction.
  assign w_v_dec  = $signed({r_v[V_W-1], r_v}) - G_EXT;
  assign w_v_grav = (w_v_dec[V_W] != w_v_dec[V_W-1]) ? V_MIN : w_v_dec[V_W-1:0];
  assign w_v_new  = w_hold_tick ? r_v : w_v_grav;

  always_comb begin
    w_phase_n = r_phase;
    w_y_n     = r_y;
    w_v_n     = r_v;
    w_hold_n  = r_hold;
    w_tcnt_n  = r_tcnt;
    w_jump_n  = 1'b0;
    w_land_n  = 1'b0;

    case (state)
      IDLE: begin
        w_phase_n = GROUND;
        w_y_n     = Y_FLOOR;
        w_v_n     = '0;
        w_hold_n  = '0;
        w_tcnt_n  = '0;
      end
      RUN: begin
        w_tcnt_n = w_tick ? '0 : r_tcnt + 1'b1;
        // Takeoff takes priority and restarts the tick phase, so a tick
        // coinciding with takeoff is dropped.
        if (w_accept && (r_phase == GROUND)) begin
          w_phase_n = RISE;
          w_y_n     = Y_TAKEOFF;
          w_v_n     = V_JUMP;
          w_hold_n  = '0;
          w_tcnt_n  = '0;
          w_jump_n  = 1'b1;
        end else if (w_tick && (r_phase != GROUND)) begin
          if (w_hold_tick) begin
            w_hold_n = r_hold + 1'b1;
          end
          if (w_sum <= S_FLOOR) begin
            w_phase_n = GROUND;
            w_y_n     = Y_FLOOR;
            w_v_n     = '0;
            w_land_n  = 1'b1;
          end else if (w_sum > S_CEIL) begin
            w_phase_n = FALL;
            w_y_n     = Y_CEIL;
            w_v_n     = '0;
          end else begin
            w_y_n     = w_sum[Y_W-1:0];
            w_v_n     = w_v_new;
            w_phase_n = (!w_v_new[V_W-1] && (w_v_new != '0)) ? RISE : FALL;
          end
        end
      end
      default: begin
        // WIN / OVER: motion frozen, tick phase restarts on return to RUN.
        w_tcnt_n = '0;
      end
    endcase

    w_air_n = (w_phase_n != GROUND);

    if (w_y_n != r_y) begin
      w_mov_n = 1'b1;
    end else if (drawDoneDino) begin
      w_mov_n = 1'b0;
    end else begin
      w_mov_n = r_mov;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_phase <= GROUND;
      r_y     <= Y_FLOOR;
      r_v     <= '0;
      r_hold  <= '0;
      r_tcnt  <= '0;
      r_jump  <= 1'b0;
      r_land  <= 1'b0;
      r_air   <= 1'b0;
      r_mov   <= 1'b0;
    end else begin
      r_phase <= w_phase_n;
      r_y     <= w_y_n;
      r_v     <= w_v_n;
      r_hold  <= w_hold_n;
      r_tcnt  <= w_tcnt_n;
      r_jump  <= w_jump_n;
      r_land  <= w_land_n;
      r_air   <= w_air_n;
      r_mov   <= w_mov_n;
    end
  end

  assign dinoY        = r_y;
  assign v            = r_v;
  assign dinoJumpGood = r_jump;
  assign airborne     = r_air;
  assign landed       = r_land;
  assign dinoMovement = r_mov;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Directed bench for dino_jump_ctrl. Three instances share the same stimulus:
//   A: MAX_HOLD=0, CEIL_Y=200 (tap jump, hold re-arm, interrupts)
//   B: MAX_HOLD=2             (variable-height jump)
//   C: CEIL_Y=106             (ceiling clamp, movement flag)
// All use TICK_DIV=4, DEBOUNCE=3, JUMP_V=3, GRAVITY=1, FLOOR_Y=101.
module tb_dino_jump_ctrl;
  import dino_jump_ctrl_pkg::*;

  logic   clk = 1'b0;
  logic   nRst;
  logic   button;
  logic   draw;
  state_t state;

  logic [7:0]        ya, yb, yc;
  logic signed [7:0] va, vb, vc;
  logic jga, jgb, jgc, aira, airb, airc, lda, ldb, ldc, mva, mvb, mvc;

  int errors = 0;
  int checks = 0;
  int jg_cnt = 0;

  int TAP_A_Y[8]  = '{107, 109, 110, 110, 109, 107, 104, 101};
  int TAP_A_V[8]  = '{2, 1, 0, -1, -2, -3, -4, 0};
  int TAP_C_Y[8]  = '{106, 106, 105, 103, 101, 101, 101, 101};
  int TAP_C_V[8]  = '{0, -1, -2, -3, 0, 0, 0, 0};
  int HOLD_B_Y[5] = '{107, 110, 113, 115, 116};
  int HOLD_B_V[5] = '{3, 3, 2, 1, 0};

  always #5 clk = ~clk;

  dino_jump_ctrl #(
    .Y_W(8), .V_W(8), .FLOOR_Y(101), .CEIL_Y(200), .JUMP_V(3), .GRAVITY(1),
    .MAX_HOLD(0), .TICK_DIV(4), .DEBOUNCE(3)
  ) u_a (
    .clk(clk), .nRst(nRst), .button(button), .state(state), .drawDoneDino(draw),
    .dinoY(ya), .v(va), .dinoJumpGood(jga), .airborne(aira), .landed(lda),
    .dinoMovement(mva)
  );

  dino_jump_ctrl #(
    .Y_W(8), .V_W(8), .FLOOR_Y(101), .CEIL_Y(200), .JUMP_V(3), .GRAVITY(1),
    .MAX_HOLD(2), .TICK_DIV(4), .DEBOUNCE(3)
  ) u_b (
    .clk(clk), .nRst(nRst), .button(button), .state(state), .drawDoneDino(draw),
    .dinoY(yb), .v(vb), .dinoJumpGood(jgb), .airborne(airb), .landed(ldb),
    .dinoMovement(mvb)
  );

  dino_jump_ctrl #(
    .Y_W(8), .V_W(8), .FLOOR_Y(101), .CEIL_Y(106), .JUMP_V(3), .GRAVITY(1),
    .MAX_HOLD(0), .TICK_DIV(4), .DEBOUNCE(3)
  ) u_c (
    .clk(clk), .nRst(nRst), .button(button), .state(state), .drawDoneDino(draw),
    .dinoY(yc), .v(vc), .dinoJumpGood(jgc), .airborne(airc), .landed(ldc),
    .dinoMovement(mvc)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (jga === 1'b1) jg_cnt++;
  endtask

  initial begin
    int prev_a;
    int prev_c;

    nRst   = 1'b0;
    button = 1'b0;
    draw   = 1'b0;
    state  = IDLE;
    #23;
    chk("rst_y_a", int'(ya), 101);
    chk("rst_v_a", int'(va), 0);
    chk("rst_jg_a", int'(jga), 0);
    chk("rst_air_a", int'(aira), 0);
    chk("rst_land_a", int'(lda), 0);
    chk("rst_mov_a", int'(mva), 0);
    chk("rst_y_c", int'(yc), 101);

    nRst = 1'b1;
    step(); step();
    chk("idle_y_a", int'(ya), 101);
    chk("idle_mov_a", int'(mva), 0);

    state = RUN;
    repeat (10) step();
    chk("run_nobtn_y_a", int'(ya), 101);
    chk("run_nobtn_jg", jg_cnt, 0);
    chk("run_nobtn_mov", int'(mva), 0);

    // Tap: button sampled high on three edges, takeoff on the third.
    button = 1'b1;
    step(); step();
    chk("tap_early_y_a", int'(ya), 101);
    step();
    button = 1'b0;
    chk("tap_jg_a", int'(jga), 1);
    chk("tap_y_a", int'(ya), 104);
    chk("tap_v_a", int'(va), 3);
    chk("tap_air_a", int'(aira), 1);
    chk("tap_mov_a", int'(mva), 1);
    chk("tap_y_c", int'(yc), 104);
    prev_a = 104;
    prev_c = 104;

    for (int i = 0; i < 8; i++) begin
      draw = 1'b1;
      step();
      draw = 1'b0;
      chk("draw_clr_a", int'(mva), 0);
      chk("draw_clr_c", int'(mvc), 0);
      chk("pulse_jg_a", int'(jga), 0);
      chk("pulse_land_a", int'(lda), 0);
      chk("pulse_land_c", int'(ldc), 0);
      step(); step(); step();
      chk("tick_y_a", int'(ya), TAP_A_Y[i]);
      chk("tick_v_a", int'($signed(va)), TAP_A_V[i]);
      chk("tick_mov_a", int'(mva), (TAP_A_Y[i] != prev_a) ? 1 : 0);
      chk("tick_land_a", int'(lda), (i == 7) ? 1 : 0);
      chk("tick_air_a", int'(aira), (i == 7) ? 0 : 1);
      chk("ceil_y_c", int'(yc), TAP_C_Y[i]);
      chk("ceil_v_c", int'($signed(vc)), TAP_C_V[i]);
      chk("ceil_mov_c", int'(mvc), (TAP_C_Y[i] != prev_c) ? 1 : 0);
      chk("ceil_land_c", int'(ldc), (i == 4) ? 1 : 0);
      chk("ceil_air_c", int'(airc), (i < 4) ? 1 : 0);
      prev_a = TAP_A_Y[i];
      prev_c = TAP_C_Y[i];
    end

    // Hold for 100 cycles: one takeoff only; B shows gravity suppression.
    repeat (4) step();
    jg_cnt = 0;
    button = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (k == 3) chk("hold_to_y_b", int'(yb), 104);
      if (k > 3 && ((k - 3) % 4) == 0 && ((k - 3) / 4) <= 5) begin
        chk("hold_y_b", int'(yb), HOLD_B_Y[(k - 3) / 4 - 1]);
        chk("hold_v_b", int'($signed(vb)), HOLD_B_V[(k - 3) / 4 - 1]);
      end
    end
    chk("hold_one_jump_a", jg_cnt, 1);
    chk("hold_landed_y_a", int'(ya), 101);
    chk("hold_air_a", int'(aira), 0);
    chk("hold_air_b", int'(airb), 0);

    // Release one cycle, re-press: second takeoff.
    button = 1'b0;
    step();
    button = 1'b1;
    step(); step(); step();
    button = 1'b0;
    chk("rearm_jg_a", int'(jga), 1);
    chk("rearm_y_a", int'(ya), 104);

    repeat (4) step();
    chk("rise_y_a", int'(ya), 107);
    chk("rise_v_a", int'($signed(va)), 2);

    // OVER mid-rise freezes motion.
    state = OVER;
    jg_cnt = 0;
    repeat (50) step();
    chk("over_y_a", int'(ya), 107);
    chk("over_v_a", int'($signed(va)), 2);
    chk("over_air_a", int'(aira), 1);
    chk("over_jg_a", jg_cnt, 0);

    // Back to RUN: fresh tick counter, first tick on the 4th edge.
    state = RUN;
    step(); step(); step();
    chk("resume_hold_y_a", int'(ya), 107);
    step();
    chk("resume_y_a", int'(ya), 109);
    chk("resume_v_a", int'($signed(va)), 1);

    // Asynchronous reset mid-jump.
    #2;
    nRst = 1'b0;
    #1;
    chk("arst_y_a", int'(ya), 101);
    chk("arst_v_a", int'($signed(va)), 0);
    chk("arst_air_a", int'(aira), 0);
    chk("arst_mov_a", int'(mva), 0);
    chk("arst_y_c", int'(yc), 101);
    #4;
    nRst = 1'b1;
    step(); step();
    chk("post_rst_y_a", int'(ya), 101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
